// File: rtl/alu_pkg.sv
// Shared ALU constants: default widths and the packed flag layout {COUT,E,G,L,OV,ERR}.
package alu_pkg;

    localparam int ALU_W   = 8;
    localparam int ALU_N   = 4;
    localparam int FLAGS_W = 6;

    localparam int FLAG_COUT = 5;
    localparam int FLAG_E    = 4;
    localparam int FLAG_G    = 3;
    localparam int FLAG_L    = 2;
    localparam int FLAG_OV   = 1;
    localparam int FLAG_ERR  = 0;

    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic cout,
        input logic e,
        input logic g,
        input logic l,
        input logic ov,
        input logic err
    );
        logic [FLAGS_W-1:0] f;
        f            = '0;
        f[FLAG_COUT] = cout;
        f[FLAG_E]    = e;
        f[FLAG_G]    = g;
        f[FLAG_L]    = l;
        f[FLAG_OV]   = ov;
        f[FLAG_ERR]  = err;
        return f;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous in-order FIFO with a registered head (no push-to-head bypass).
module alu_res_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [DATA_W-1:0]            head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // The next head is either the word being pushed into an (effectively) empty
            // FIFO or the already-stored word at the advanced read pointer.
            if (do_push && ((count_q - CNT_W'(do_pop)) == '0)) begin
                head_d = push_data;
            end else if (count_d != '0) begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head       = head_q;

endmodule

// File: rtl/alu_result_capture.sv
// Tracks ALU issues through a CE-gated shadow pipeline, captures RES/flags when they
// become valid and buffers them with their tag behind a credit-protected FIFO.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CE,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [TAGW-1:0]      issue_tag,
    output logic                 issue_ready,
    input  logic [2*W-1:0]       RES,
    input  logic                 COUT,
    input  logic                 OV,
    input  logic                 ERR,
    input  logic                 G,
    input  logic                 L,
    input  logic                 E,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAGW-1:0]      out_tag,
    output logic [2*W-1:0]       out_res,
    output logic [FLAGS_W-1:0]   out_flags,
    output logic                 protocol_err,
    output logic [15:0]          err_count
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = TAGW + 2*W + FLAGS_W;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [LAT-1:0]     sh_vld_q, sh_vld_d;
    logic [TAGW-1:0]    sh_tag_q [LAT];
    logic [TAGW-1:0]    sh_tag_d [LAT];
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               protocol_err_q, protocol_err_d;
    logic [15:0]        err_count_q, err_count_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               accept, capture, pop;

    // Credit comes only from registered counters, so a pop frees a slot one cycle later.
    assign issue_ready = (SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);
    assign accept      = issue_valid && CE && issue_ready && !flush;
    assign capture     = CE && sh_vld_q[LAT-1] && !flush;
    assign pop         = out_valid && out_ready;
    assign push_data   = {sh_tag_q[LAT-1], RES, pack_flags(COUT, E, G, L, OV, ERR)};

    always_comb begin
        sh_vld_d       = sh_vld_q;
        sh_tag_d       = sh_tag_q;
        inflight_d     = inflight_q;
        protocol_err_d = protocol_err_q || (issue_valid && CE && !issue_ready);
        err_count_d    = (capture && ERR) ? sat_inc16(err_count_q) : err_count_q;
        if (flush) begin
            sh_vld_d   = '0;
            inflight_d = '0;
        end else if (CE) begin
            for (int i = LAT - 1; i >= 1; i--) begin
                sh_vld_d[i] = sh_vld_q[i-1];
                sh_tag_d[i] = sh_tag_q[i-1];
            end
            sh_vld_d[0] = accept;
            sh_tag_d[0] = issue_tag;
            inflight_d  = inflight_q + CNT_W'(accept) - CNT_W'(sh_vld_q[LAT-1]);
        end
    end

    always_ff @(posedge clk) begin
        sh_tag_q <= sh_tag_d;
        if (rst) begin
            sh_vld_q       <= '0;
            inflight_q     <= '0;
            protocol_err_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            sh_vld_q       <= sh_vld_d;
            inflight_q     <= inflight_d;
            protocol_err_q <= protocol_err_d;
            err_count_q    <= err_count_d;
        end
    end

    alu_res_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (capture),
        .push_data  (push_data),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (out_valid),
        .head       (head)
    );

    assign out_tag      = head[ENTRY_W-1 -: TAGW];
    assign out_res      = head[FLAGS_W +: 2*W];
    assign out_flags    = head[FLAGS_W-1:0];
    assign protocol_err = protocol_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture with a CE-gated ALU stand-in and an in-order scoreboard.
module tb_alu_result_capture;
    import alu_pkg::*;

    localparam int W     = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    typedef struct packed {
        logic [TAGW-1:0]    tag;
        logic [2*W-1:0]     res;
        logic [FLAGS_W-1:0] flags;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst, CE, flush, issue_valid, issue_ready;
    logic [TAGW-1:0]    issue_tag;
    logic [2*W-1:0]     RES;
    logic               COUT, OV, ERR, G, L, E;
    logic               out_valid, out_ready;
    logic [TAGW-1:0]    out_tag;
    logic [2*W-1:0]     out_res;
    logic [FLAGS_W-1:0] out_flags;
    logic               protocol_err;
    logic [15:0]        err_count;

    logic [2*W-1:0]         op_res;
    logic [FLAGS_W-1:0]     op_flags;
    logic [2*W+FLAGS_W-1:0] alu_pipe [LAT];

    ent_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in for the upstream ALU: result appears LAT CE-enabled edges after its inputs.
    always @(posedge clk) begin
        if (CE) begin
            alu_pipe[0] <= {op_flags, op_res};
            for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign RES                     = alu_pipe[LAT-1][2*W-1:0];
    assign {COUT, E, G, L, OV, ERR} = alu_pipe[LAT-1][2*W+FLAGS_W-1:2*W];

    alu_result_capture #(.W(W), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .CE(CE), .flush(flush),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .RES(RES), .COUT(COUT), .OV(OV), .ERR(ERR), .G(G), .L(L), .E(E),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_res(out_res), .out_flags(out_flags),
        .protocol_err(protocol_err), .err_count(err_count)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    task automatic alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] inpv,
                             output logic [2*W-1:0] r, output logic [FLAGS_W-1:0] f);
        logic [W:0] s;
        f = '0;
        if (inpv == 2'b00) begin
            r           = '0;
            f[FLAG_ERR] = 1'b1;
        end else begin
            s            = {1'b0, a} + {1'b0, b};
            r            = {{(W-1){1'b0}}, s};
            f[FLAG_COUT] = s[W];
        end
    endtask

    // One clock: retire the head against the scoreboard if it is being popped.
    task automatic cyc();
        ent_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_entry", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pop_tag",   32'(out_tag),   32'(e.tag));
                check("pop_res",   32'(out_res),   32'(e.res));
                check("pop_flags", 32'(out_flags), 32'(e.flags));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [TAGW-1:0] tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] inpv, input logic exp_ready);
        logic [2*W-1:0]     r;
        logic [FLAGS_W-1:0] f;
        alu_model(a, b, inpv, r, f);
        issue_valid = 1'b1;
        issue_tag   = tag;
        op_res      = r;
        op_flags    = f;
        check("issue_ready", 32'(issue_ready), 32'(exp_ready));
        if (exp_ready && CE) sb.push_back('{tag: tag, res: r, flags: f});
        cyc();
        issue_valid = 1'b0;
        issue_tag   = '0;
        op_res      = 16'hDEAD;
        op_flags    = 6'b101010;
    endtask

    initial begin
        rst = 1'b1; CE = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_tag = '0;
        out_ready = 1'b0; op_res = 16'hDEAD; op_flags = 6'b101010;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);

        // Single issue, latency 2
        out_ready = 1'b1;
        issue(4'd3, 8'd10, 8'd5, 2'b11, 1'b1);
        check("t1_valid_e0", 32'(out_valid), 32'd0);
        cyc();
        check("t1_valid_e1", 32'(out_valid), 32'd0);
        cyc();
        check("t1_valid_e2", 32'(out_valid), 32'd1);
        check("t1_tag", 32'(out_tag), 32'd3);
        check("t1_res", 32'(out_res), 32'd15);
        check("t1_flags", 32'(out_flags), 32'd0);
        cyc();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Four back-to-back issues fill the credit
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(4'(i), 8'(60*i + 50), 8'(70*i + 9), 2'b11, 1'b1);
        check("t2_credit_gone", 32'(issue_ready), 32'd0);
        repeat (2) cyc();
        check("t2_full_valid", 32'(out_valid), 32'd1);
        check("t2_full_tag0", 32'(out_tag), 32'd0);
        out_ready = 1'b1;
        check("t2_ready_pop_cycle", 32'(issue_ready), 32'd0);
        cyc();
        check("t2_ready_after_pop", 32'(issue_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check("t2_one_per_cycle", 32'(out_valid), 32'd1);
            cyc();
        end
        check("t2_drained", 32'(out_valid), 32'd0);

        // CE stall delays capture; an issue while CE=0 is ignored
        issue(4'd5, 8'd33, 8'd44, 2'b11, 1'b1);
        CE = 1'b0;
        cyc();
        check("t3_stall_e1", 32'(out_valid), 32'd0);
        issue(4'd9, 8'd1, 8'd1, 2'b11, 1'b1);
        cyc();
        CE = 1'b1;
        cyc();
        check("t3_stall_e4", 32'(out_valid), 32'd0);
        cyc();
        check("t3_valid_e5", 32'(out_valid), 32'd1);
        check("t3_tag", 32'(out_tag), 32'd5);
        check("t3_res", 32'(out_res), 32'd77);
        repeat (3) cyc();
        check("t3_no_ce0_entry", 32'(out_valid), 32'd0);
        check("t3_no_protocol_err", 32'(protocol_err), 32'd0);

        // ERR results
        for (int i = 0; i < 3; i++) issue(4'(8 + i), 8'd3, 8'd4, 2'b00, 1'b1);
        repeat (3) cyc();
        check("t4_err_count", 32'(err_count), 32'd3);
        check("t4_drained", 32'(out_valid), 32'd0);

        // Flush with one buffered and one in flight
        out_ready = 1'b0;
        issue(4'd6, 8'd1, 8'd2, 2'b11, 1'b1);
        issue(4'd7, 8'd3, 8'd4, 2'b11, 1'b1);
        cyc();
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        sb.delete();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_issue_ready", 32'(issue_ready), 32'd1);
        check("fl_err_kept", 32'(err_count), 32'd3);
        out_ready = 1'b1;
        repeat (LAT + 1) cyc();
        check("fl_no_stale", 32'(out_valid), 32'd0);

        // Issue without credit
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(4'(10 + i), 8'(11*i + 1), 8'(13*i + 2), 2'b11, 1'b1);
        issue(4'd14, 8'd99, 8'd99, 2'b11, 1'b0);
        check("t5_protocol_err", 32'(protocol_err), 32'd1);
        repeat (3) cyc();
        check("t5_sticky", 32'(protocol_err), 32'd1);
        check("t5_full_valid", 32'(out_valid), 32'd1);
        check("t5_still_full", 32'(issue_ready), 32'd0);
        out_ready = 1'b1;
        repeat (4) cyc();
        check("t5_no_fifth", 32'(out_valid), 32'd0);
        repeat (2) cyc();
        check("t5_no_fifth_late", 32'(out_valid), 32'd0);
        check("t5_sticky_late", 32'(protocol_err), 32'd1);

        // Reset mid-flight: two in flight, one buffered
        out_ready = 1'b0;
        issue(4'd1, 8'd5, 8'd6, 2'b11, 1'b1);
        issue(4'd2, 8'd7, 8'd8, 2'b00, 1'b1);
        issue(4'd3, 8'd9, 8'd1, 2'b11, 1'b1);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_err_count", 32'(err_count), 32'd3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sb.delete();
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_issue_ready", 32'(issue_ready), 32'd1);
        check("t6_err_count", 32'(err_count), 32'd0);
        check("t6_protocol_err", 32'(protocol_err), 32'd0);
        check("t6_out_res", 32'(out_res), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            cyc();
            check("t6_no_stale", 32'(out_valid), 32'd0);
        end

        // err_count saturation
        for (int k = 0; k < 65535; k++) issue(4'(k), 8'd0, 8'd0, 2'b00, 1'b1);
        repeat (3) cyc();
        check("sat_reach", 32'(err_count), 32'h0000FFFF);
        for (int k = 0; k < 2; k++) issue(4'(k), 8'd0, 8'd0, 2'b00, 1'b1);
        repeat (3) cyc();
        check("sat_hold", 32'(err_count), 32'h0000FFFF);
        check("sat_drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
Downstream stage of aluDesign. It tracks each operation issued to the ALU through a latency-matched shadow pipeline. At the cycle the result is valid it samples RES and flags, then buffers them with the issue tag in a small in-order FIFO behind a valid/ready interface. A credit check (issue_ready) guarantees the FIFO can never overflow. It also keeps a saturating count of ERR results.

Parameters:
W, 8, ALU operand width; RES is 2*W.
LAT, 2, CE-enabled clock edges from the issue edge to the edge where RES/flags are valid; legal range 1..8.
DEPTH, 4, result FIFO entries; power of two, at least 2.
TAGW, 4, issue tag width.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
CE  in  1  same clock enable that drives the ALU
flush  in  1  clears the shadow pipeline and the FIFO
issue_valid  in  1  ALU inputs this cycle form an operation to track
issue_tag  in  TAGW  caller's tag for that operation
issue_ready  out  1  credit is available
RES  in  2*W  ALU result
COUT, OV, ERR, G, L, E  in  1 each  ALU flags
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer accepts the head
out_tag  out  TAGW  tag of the head entry
out_res  out  2*W  result of the head entry
out_flags  out  6  {COUT,E,G,L,OV,ERR} of the head entry
protocol_err  out  1  sticky; set by an issue without credit
err_count  out  16  saturating count of captured ERR=1 results

Behaviour:
- Reset (rst=1 at an edge): at that edge clear shadow valids, FIFO pointers and count, err_count and protocol_err.
  - After reset: out_valid=0, out_tag=0, out_res=0, out_flags=0, issue_ready=1.
  - A reset in mid-flight discards all in-flight and buffered results.
- flush: same clearing as reset except err_count and protocol_err are kept. flush has priority over push, pop and issue in the same cycle.
- Issue acceptance: an issue is accepted when issue_valid & CE & issue_ready at the edge. issue_valid with CE=0 is ignored.
- Credit:
  - issue_ready = (inflight + fifo_count) < DEPTH. It is combinational from registered counters only.
  - inflight is the number of valid shadow stages.
  - A pop in the current cycle does not free credit until the next cycle.
- Protocol violation: issue_valid & CE & !issue_ready sets protocol_err. The operation is not tracked.
- Shadow pipeline:
  - LAT stages of {valid,tag}. It shifts only on edges with CE=1 and holds when CE=0.
  - The accepted issue enters stage 1.
- Capture: on an edge where CE=1 and stage LAT is valid, push {tag, RES, flags} into the FIFO at that same edge.
  - out_valid rises after edge t0+LAT, where t0 is the issue edge, plus one extra edge per CE=0 cycle in between.
- FIFO:
  - In-order, registered outputs, no bypass. A push into an empty FIFO shows at the head the following cycle.
  - A pop occurs when out_valid & out_ready.
  - A simultaneous push and pop keeps the count unchanged; this is legal even at count=DEPTH.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - Pointers wrap modulo DEPTH.
- err_count: +1 per push with ERR=1, saturating at 16'hFFFF. No wrap.
- Widths: inflight and fifo_count are sized for DEPTH. The credit compare is done unsigned, without truncation.

Decomposition:
- alu_pkg:
  - flag bit positions (COUT=5, E=4, G=3, L=2, OV=1, ERR=0);
  - the FLAGS_W=6 constant;
  - default W and N, shared with aluDesign.
- Sub-module alu_res_fifo: generic synchronous FIFO with parameters data width and DEPTH, ports push, pop, flush, count, head.
- The shadow pipeline, credit logic and err_count stay in the top level.

Test Plan:
1. Single issue, LAT=2: OPA=8'd10, OPB=8'd5, ADD, MODE=1, tag 3, out_ready=1 → out_valid=1 in the cycle after the 2nd edge; out_res=16'd15, out_tag=3, out_flags=6'b000000.
2. Four back-to-back issues, tags 0..3, out_ready=0, DEPTH=4 → issue_ready=0 after the 4th issue. Raise out_ready → tags 0,1,2,3 pop in order, one per cycle, with correct results. issue_ready returns to 1 the cycle after the first pop.
3. Tag 5 issued, then CE=0 for 3 cycles → capture is delayed by exactly 3 cycles (out_valid after edge t0+5); out_res is unchanged from the CE=1 value.
4. INP_VALID=2'b00 op producing ERR=1, repeated 3 times → out_flags[0]=1 on each entry; err_count=3. A preloaded err_count of 16'hFFFF stays at 16'hFFFF.
5. Issue with issue_ready=0 (FIFO full, out_ready=0) → protocol_err=1 and stays set; no 5th entry appears; the FIFO contents are intact.
6. rst=1 for one cycle with 2 ops in flight and 1 buffered → next cycle out_valid=0, issue_ready=1, err_count=0; no stale result emerges within LAT+2 cycles.
